// File: rtl/sram_rr_port_arbiter.sv
// Shares one dual-port SRAM between N_REQ requesters. Separate round-robin
// arbiters own the write port and the read port; read data returns one cycle after grant.
module sram_rr_port_arbiter #(
  parameter  int N_REQ      = 3,
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]      req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]            rsp_data,
  output logic                        sram_cs,
  output logic                        sram_we,
  output logic                        sram_oe,
  output logic [ADDR_WIDTH-1:0]       sram_raddr,
  output logic [ADDR_WIDTH-1:0]       sram_waddr,
  output logic [WIDTH-1:0]            sram_wdata,
  input  logic [WIDTH-1:0]            sram_rdata
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  rsp_pending_q, rsp_pending_d;
  logic [PTR_W-1:0]      rsp_owner_q, rsp_owner_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

  logic [N_REQ-1:0]      rd_cand, wr_cand;
  logic                  rd_found, wr_found;
  logic [PTR_W-1:0]      rd_win, wr_win;
  logic [N_REQ-1:0]      rd_onehot, wr_onehot;
  logic [ADDR_WIDTH-1:0] waddr_sel;
  logic [WIDTH-1:0]      wdata_sel;

  // First candidate at or above ptr, wrapping modulo N_REQ.
  function automatic void rr_pick(input  logic [N_REQ-1:0] cand,
                                  input  logic [PTR_W-1:0] ptr,
                                  output logic             found,
                                  output logic [PTR_W-1:0] win);
    int idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] win);
    return (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  endfunction

  always_comb begin
    rd_cand = req_valid & ~req_write;
    wr_cand = req_valid & req_write;
    rr_pick(rd_cand, rd_ptr_q, rd_found, rd_win);
    rr_pick(wr_cand, wr_ptr_q, wr_found, wr_win);

    rd_onehot = rd_found ? (N_REQ'(1) << rd_win) : '0;
    wr_onehot = wr_found ? (N_REQ'(1) << wr_win) : '0;
    waddr_sel = req_addr[int'(wr_win)*ADDR_WIDTH +: ADDR_WIDTH];
    wdata_sel = req_wdata[int'(wr_win)*WIDTH +: WIDTH];

    rd_ptr_d      = rd_found ? ptr_after(rd_win) : rd_ptr_q;
    wr_ptr_d      = wr_found ? ptr_after(wr_win) : wr_ptr_q;
    rsp_pending_d = rd_found;
    rsp_owner_d   = rd_found ? rd_win : rsp_owner_q;
    raddr_d       = rd_found ? req_addr[int'(rd_win)*ADDR_WIDTH +: ADDR_WIDTH] : raddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= '0;
      raddr_q       <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
      raddr_q       <= raddr_d;
    end
  end

  // Outputs are held at zero for the whole time reset is asserted.
  always_comb begin
    req_ready  = rst_n ? (rd_onehot | wr_onehot) : '0;
    rsp_valid  = (rst_n && rsp_pending_q) ? (N_REQ'(1) << rsp_owner_q) : '0;
    rsp_data   = (rst_n && rsp_pending_q) ? sram_rdata : '0;
    sram_we    = rst_n & wr_found;
    sram_oe    = rst_n & (rd_found | rsp_pending_q);
    sram_cs    = sram_we | sram_oe;
    sram_raddr = rst_n ? raddr_d : '0;
    sram_waddr = (rst_n && wr_found) ? waddr_sel : '0;
    sram_wdata = (rst_n && wr_found) ? wdata_sel : '0;
  end

endmodule

// File: doc/sram_rr_port_arbiter.md
Name: sram_rr_port_arbiter

Overview:
- Shares one dual_port_sram instance between N_REQ requesters.
- Each requester issues single-word read or write requests over a valid/ready handshake.
- Two independent round-robin arbiters run every cycle: one owns the SRAM write port, one owns the read port. One read and one write can therefore complete in the same cycle.
- Read data returns to the winning requester one cycle after its grant, as a one-hot response strobe plus a shared data bus.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 8, data word width; must equal the SRAM WIDTH.
- DEPTH, 16, SRAM word count; ADDR_WIDTH = $clog2(DEPTH) (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_write  input  N_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  N_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  N_REQ*WIDTH  flattened write data; requester i at [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  grant; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  output  N_REQ  one-hot read-response strobe.
- rsp_data  output  WIDTH  read data, valid when any rsp_valid bit is set.
- sram_cs  output  1  SRAM chip_select.
- sram_we  output  1  SRAM write_enable.
- sram_oe  output  1  SRAM output_enable.
- sram_raddr  output  ADDR_WIDTH  SRAM read_address.
- sram_waddr  output  ADDR_WIDTH  SRAM write_address.
- sram_wdata  output  WIDTH  SRAM write_data.
- sram_rdata  input  WIDTH  SRAM read_data.

Behaviour:
- Reset (async, rst_n low):
  - rd_ptr = 0, wr_ptr = 0.
  - rsp_valid = 0, rsp_pending = 0, rsp_owner = 0.
  - Registered sram_raddr = 0.
  - rsp_data and all other outputs forced to 0 while rst_n is low.
  - A read granted in the cycle before reset asserts is dropped; no response is issued after reset releases.
- Candidate sets, evaluated combinationally each cycle:
  - Read candidates: req_valid & ~req_write.
  - Write candidates: req_valid & req_write.
  - A requester presents one operation per cycle, so it can only ever be in one set.
- Round-robin selection:
  - Winner is the first candidate found searching from the pointer upward, wrapping modulo N_REQ.
  - req_ready = one-hot read winner OR one-hot write winner. It is purely combinational from req_valid, req_write and the pointers; it does not depend on rsp state.
  - On a granted read, rd_ptr <= winner + 1, wrapping N_REQ-1 -> 0.
  - On a granted write, wr_ptr <= winner + 1, with the same wrap.
  - A pointer holds when its port has no grant.
- Write path, same cycle as grant:
  - sram_we = write grant.
  - sram_waddr and sram_wdata are muxed from the winner.
  - The write commits at the closing edge.
- Read path:
  - Grant cycle T: sram_oe = 1; sram_raddr = winner address, driven combinationally.
  - Edge ending T: rsp_pending <= 1, rsp_owner <= winner.
  - Cycle T+1: rsp_valid[rsp_owner] = 1 and rsp_data = sram_rdata.
  - sram_oe stays 1 during T+1 whether or not a new read is granted, so the SRAM output is not tristated.
  - Result: one-cycle read latency, full throughput with back-to-back reads.
  - When there is no read grant, sram_raddr holds its last value.
- Chip select: sram_cs = sram_we | sram_oe.
- Same-address read and write in one cycle: both are granted. The SRAM returns the NEW data at T+1 through its internal bypass. The arbiter adds no hazard logic.
- Requesters must hold req_valid and all request fields stable until ready. A deasserted request is simply not a candidate and causes no error.
- No candidates on a port: that port's enable is 0 (except oe during a response cycle) and its pointer holds.

Test Plan:
- Reset, then write req0 addr 3 data 0xA5; read req1 addr 3 one cycle later -> req_ready[1] at T; rsp_valid=3'b010 and rsp_data=0xA5 at T+1.
- req0, req1, req2 all hold valid reads (addrs 0, 1, 2, preloaded 0x10/0x11/0x12) -> grants in order 0, 1, 2, 0; rsp_valid one-hot each cycle with 0x10, 0x11, 0x12, 0x10; no bubbles.
- Same cycle: req0 writes addr 5 = 0x3C and req2 reads addr 5 (old 0x00) -> both readies high; rsp_data=0x3C at T+1.
- Same cycle: req1 writes and req0 reads, both with pointers at 0 -> both granted; rd_ptr=1, wr_ptr=2 afterwards.
- Pointer wrap: rd_ptr=2 with only req0 and req2 reading -> grant req2, then req0; rd_ptr goes 2 -> 0 -> 1.
- Read granted at T, rst_n pulsed low mid-cycle T+1 -> rsp_valid=0 immediately; after release both pointers are 0 and no response appears.
